// File: rtl/store_pack_buffer.sv
// Store-side packer: aligns MEM-stage sw/sh/sb requests onto the 32-bit data bus,
// queues them in a small FIFO and issues them to data memory with req/ack.
module store_pack_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1:0]       st_op,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             align_err,
  output logic [31:0]      err_addr,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             align_err_q, align_err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic             accept, fault, push, pop;
  logic [31:0]      pk_data;
  logic [3:0]       pk_be;

  // Lane replication and byte-enable generation for the incoming request.
  always_comb begin
    fault   = 1'b0;
    pk_data = st_data;
    pk_be   = 4'b1111;
    case (st_op)
      OP_SW: fault = (st_addr[1:0] != 2'b00);
      OP_SH: begin
        fault   = st_addr[0];
        pk_data = {st_data[15:0], st_data[15:0]};
        pk_be   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        pk_data = {4{st_data[7:0]}};
        pk_be   = 4'b0001 << st_addr[1:0];
      end
      default: fault = 1'b1;
    endcase
  end

  // Status flags derive only from registered state, so reset drops mem_req at once.
  always_comb begin
    st_ready = ({1'b0, count_q} < (CNT_W + 1)'(DEPTH));
    empty    = (count_q == '0);
    mem_req  = !empty;
    accept   = st_valid && st_ready;
    push     = accept && !fault;
    pop      = mem_req && mem_ack;
  end

  always_comb begin
    wptr_d      = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d      = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    align_err_d = accept && fault;
    err_addr_d  = (accept && fault) ? st_addr : err_addr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      align_err_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      align_err_q <= align_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= {st_addr[31:2], 2'b00};
      data_q[wptr_q] <= pk_data;
      be_q[wptr_q]   <= pk_be;
    end
  end

  always_comb begin
    mem_addr  = addr_q[rptr_q];
    mem_wdata = data_q[rptr_q];
    mem_be    = be_q[rptr_q];
    count     = count_q;
    align_err = align_err_q;
    err_addr  = err_addr_q;
  end

endmodule

// File: tb/tb_store_pack_buffer.sv
// Directed bench for store_pack_buffer: a queue-based reference model checked every
// cycle, plus literal expectations taken from the store/alignment rules.
module tb_store_pack_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        align_err;
  logic [31:0] err_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  count;
  logic        empty;

  int checks = 0;
  int failures = 0;

  store_pack_buffer #(.DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data),
    .align_err(align_err), .err_addr(err_addr),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: each entry is {word address, lane data, byte enables}.
  logic [67:0] mq[$];
  logic        m_align;
  logic [31:0] m_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_align = 1'b0;
      m_err   = 32'h0;
    end else begin
      logic        acc, flt, pp;
      logic [31:0] d;
      logic [3:0]  b;
      acc = st_valid && (mq.size() < DEPTH);
      flt = (st_op == 2'd3) || (st_op == 2'd0 && st_addr % 4 != 0) ||
            (st_op == 2'd1 && st_addr % 2 != 0);
      pp  = (mq.size() > 0) && mem_ack;
      d = st_data;
      b = 4'hF;
      if (st_op == 2'd1) begin
        d = {16'h0, st_data[15:0]} * 32'h0001_0001;
        b = (st_addr & 32'h2) != 0 ? 4'hC : 4'h3;
      end else if (st_op == 2'd2) begin
        d = {24'h0, st_data[7:0]} * 32'h0101_0101;
        b = 4'h1 << (st_addr % 4);
      end
      m_align = acc && flt;
      if (acc && flt) m_err = st_addr;
      if (pp) void'(mq.pop_front());
      if (acc && !flt) mq.push_back({st_addr - (st_addr % 4), d, b});
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("m_ready", {31'h0, st_ready}, {31'h0, mq.size() < DEPTH});
      chk("m_req",   {31'h0, mem_req},  {31'h0, mq.size() > 0});
      chk("m_count", {30'h0, count},    mq.size());
      chk("m_empty", {31'h0, empty},    {31'h0, mq.size() == 0});
      chk("m_aerr",  {31'h0, align_err}, {31'h0, m_align});
      chk("m_eaddr", err_addr, m_err);
      if (mq.size() > 0) begin
        chk("m_addr",  mem_addr,  mq[0][67:36]);
        chk("m_wdata", mem_wdata, mq[0][35:4]);
        chk("m_be",    {28'h0, mem_be}, {28'h0, mq[0][3:0]});
      end
    end
  end

  task automatic put(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    st_op    = 2'd0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
  endtask

  task automatic head(input string n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    chk({n, "_addr"},  mem_addr,  a);
    chk({n, "_wdata"}, mem_wdata, d);
    chk({n, "_be"},    {28'h0, mem_be}, {28'h0, b});
  endtask

  initial begin
    reset   = 1'b0;
    mem_ack = 1'b0;
    idle();
    #1;
    chk("rst_count", {30'h0, count}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_ready", {31'h0, st_ready}, 32'd1);
    chk("rst_req",   {31'h0, mem_req}, 32'd0);
    chk("rst_aerr",  {31'h0, align_err}, 32'd0);
    chk("rst_eaddr", err_addr, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Single sw, popped on the next edge.
    put(2'd0, 32'h1000, 32'hDEADBEEF);
    mem_ack = 1'b1;
    @(negedge clk); idle();
    chk("sw_req", {31'h0, mem_req}, 32'd1);
    head("sw", 32'h1000, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    chk("sw_empty", {31'h0, empty}, 32'd1);
    mem_ack = 1'b0;

    // sb lane replication, then sh pushed on the pop edge.
    put(2'd2, 32'h2003, 32'h0000_00A5);
    @(negedge clk);
    head("sb", 32'h2000, 32'hA5A5A5A5, 4'b1000);
    put(2'd1, 32'h2002, 32'h0000_1234);
    mem_ack = 1'b1;
    @(negedge clk); idle();
    head("sh", 32'h2000, 32'h12341234, 4'b1100);
    chk("sh_count", {30'h0, count}, 32'd1);
    @(negedge clk);
    chk("sh_empty", {31'h0, empty}, 32'd1);
    mem_ack = 1'b0;

    // Misaligned sh coinciding with a pop, then an invalid op.
    put(2'd0, 32'h3100, 32'h0);
    @(negedge clk);
    put(2'd1, 32'h3001, 32'h5555);
    mem_ack = 1'b1;
    @(negedge clk); idle();
    mem_ack = 1'b0;
    chk("mis_aerr",  {31'h0, align_err}, 32'd1);
    chk("mis_eaddr", err_addr, 32'h3001);
    chk("mis_count", {30'h0, count}, 32'd0);
    chk("mis_req",   {31'h0, mem_req}, 32'd0);
    put(2'd3, 32'h4000, 32'h0);
    @(negedge clk); idle();
    chk("inv_aerr",  {31'h0, align_err}, 32'd1);
    chk("inv_eaddr", err_addr, 32'h4000);
    @(negedge clk);
    chk("pulse_end", {31'h0, align_err}, 32'd0);
    chk("inv_count", {30'h0, count}, 32'd0);

    // Back-pressure: third store is held until space frees up.
    put(2'd0, 32'h5000, 32'h11111111);
    @(negedge clk);
    put(2'd0, 32'h5004, 32'h22222222);
    @(negedge clk);
    chk("full_count", {30'h0, count}, 32'd2);
    chk("full_ready", {31'h0, st_ready}, 32'd0);
    put(2'd0, 32'h5008, 32'h33333333);
    @(negedge clk);
    chk("stall_count", {30'h0, count}, 32'd2);
    head("stall1", 32'h5000, 32'h11111111, 4'hF);
    @(negedge clk);
    head("stall2", 32'h5000, 32'h11111111, 4'hF);
    mem_ack = 1'b1;
    @(negedge clk);
    head("drainB", 32'h5004, 32'h22222222, 4'hF);
    @(negedge clk); idle();
    head("drainC", 32'h5008, 32'h33333333, 4'hF);
    @(negedge clk);
    chk("drain_empty", {31'h0, empty}, 32'd1);

    // Streaming push+pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      put(2'd0, 32'h6000 + 4 * i, 32'h0101_0101 * i);
      @(negedge clk);
      chk("stream_count", {30'h0, count}, 32'd1);
      chk("stream_addr", mem_addr, 32'h6000 + 4 * i);
    end
    idle();
    @(negedge clk);
    chk("stream_empty", {31'h0, empty}, 32'd1);
    mem_ack = 1'b0;

    // Asynchronous reset with two entries queued.
    put(2'd0, 32'h7000, 32'h7);
    @(negedge clk);
    put(2'd0, 32'h7004, 32'h8);
    @(negedge clk); idle();
    chk("pre_rst_count", {30'h0, count}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_req",   {31'h0, mem_req}, 32'd0);
    chk("arst_count", {30'h0, count}, 32'd0);
    chk("arst_empty", {31'h0, empty}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    put(2'd0, 32'h8000, 32'hCAFEF00D);
    mem_ack = 1'b1;
    @(negedge clk); idle();
    chk("post_req", {31'h0, mem_req}, 32'd1);
    head("post", 32'h8000, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    chk("post_empty", {31'h0, empty}, 32'd1);
    mem_ack = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_pack_buffer.md
Name: store_pack_buffer

Overview:
- Write-side counterpart to the immediate/load-data extension path: takes store requests (sw/sh/sb) from the pipeline's MEM stage and narrows them onto the 32-bit data-memory write bus.
- Replicates sub-word data across lanes, generates byte enables and word-aligns the address.
- Queues requests in a small FIFO and issues them to data memory with a req/ack handshake.
- Flags misaligned or invalid stores instead of issuing them.

Parameters:
- DEPTH, 2, number of buffered store entries (power of two, ≥2).
- CNT_W, 2, width of the occupancy counter; must hold 0..DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- st_valid  input  1  store request valid.
- st_ready  output  1  buffer can accept a request this cycle.
- st_op  input  2  00 = sw, 01 = sh, 10 = sb, 11 = invalid.
- st_addr  input  32  byte address.
- st_data  input  32  store data (rt value), right-justified.
- align_err  output  1  one-cycle pulse: the accepted request was misaligned or invalid.
- err_addr  output  32  byte address of the last faulting request.
- mem_req  output  1  head entry valid toward data memory.
- mem_ack  input  1  memory accepts the head entry this cycle.
- mem_addr  output  32  head address, with [1:0] forced to 00.
- mem_wdata  output  32  head lane-replicated data.
- mem_be  output  4  head byte enables.
- count  output  CNT_W  current occupancy.
- empty  output  1  count == 0.

Behaviour:
- Reset (asynchronous, reset = 0): count = 0, read/write pointers = 0, mem_req = 0, align_err = 0, err_addr = 0, empty = 1, st_ready = 1. Entry storage need not be cleared.
- Reset asserted mid-transaction drops all queued stores. mem_req falls immediately, without waiting for a clock edge.
- st_ready = (count < DEPTH). It is combinational from registered state only and never depends on mem_ack.
- Accept occurs at a rising edge when st_valid && st_ready.
- Alignment check on the accepted request:
  - sw requires st_addr[1:0] == 00.
  - sh requires st_addr[0] == 0.
  - sb is always aligned.
  - op 11 is always a fault.
- Faulting request: not enqueued. align_err = 1 for exactly the following cycle. err_addr <= st_addr. count is unchanged.
- Good request: enqueued at the write pointer with:
  - sw: wdata = st_data, be = 1111.
  - sh: wdata = {st_data[15:0], st_data[15:0]}; be = 0011 if addr[1] = 0, else 1100.
  - sb: wdata = {4{st_data[7:0]}}; be = 0001 << addr[1:0].
  - Stored address = {st_addr[31:2], 2'b00}.
- Latency: a request accepted at edge t into an empty buffer has mem_req = 1 from t+1.
- mem_req = !empty. mem_addr, mem_wdata and mem_be come from the head entry.
- While mem_req && !mem_ack, all mem_* outputs hold stable.
- Pop occurs at an edge where mem_req && mem_ack. mem_ack while mem_req = 0 is ignored.
- Simultaneous good push and pop: count is unchanged and both pointers advance. When count == DEPTH this cannot happen, because st_ready = 0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. FIFO order is strictly preserved.
- Fault on the same edge as a pop: count decrements and align_err still pulses.
- No combinational path from st_* to mem_*.

Test Plan:
- Reset, then sw addr 0x1000 data 0xDEADBEEF, mem_ack = 1 → next cycle mem_req = 1, mem_addr = 0x1000, wdata = 0xDEADBEEF, be = 1111; popped the following edge, empty = 1.
- sb addr 0x2003 data 0x000000A5 → wdata = 0xA5A5A5A5, be = 1000, mem_addr = 0x2000. sh addr 0x2002 data 0x1234 → wdata = 0x12341234, be = 1100.
- sh addr 0x3001 → align_err pulses for 1 cycle, err_addr = 0x3001, count stays 0, mem_req stays 0. op 11 at 0x4000 → same behaviour, err_addr = 0x4000.
- mem_ack = 0, issue 3 stores back-to-back → first two accepted, st_ready = 0 at count = 2, third held. Raise mem_ack → stores drain in order; third accepted on the pop edge. Check mem_* stable while stalled.
- Continuous push + ack over 10 requests → count stays 1, pointers wrap correctly, output order matches input order.
- Two entries queued, then reset = 0 between edges → mem_req = 0, count = 0 immediately. After release, the first new store issues correctly.
